// File: rtl/fpmult_radix_sat_if.sv
// Operand/result stream bundle for fpmult_radix_sat: val/rdy on the operand
// side, val/rdy on the result side, plus the overflow flag.
interface fpmult_radix_sat_if #(
  parameter int n = 32
);
  logic         recv_val;
  logic         recv_rdy;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         send_val;
  logic         send_rdy;
  logic [n-1:0] c;
  logic         ovf;

  modport master (
    output recv_val, a, b, send_rdy,
    input  recv_rdy, send_val, c, ovf
  );

  modport slave (
    input  recv_val, a, b, send_rdy,
    output recv_rdy, send_val, c, ovf
  );
endinterface

// File: rtl/fpmult_radix_sat.sv
// Iterative fixed-point multiplier retiring K multiplier bits per cycle, with
// optional round-half-up at bit d-1 and optional saturation on overflow.
module fpmult_radix_sat #(
  parameter int n     = 32,
  parameter int d     = 16,
  parameter int sign  = 1,
  parameter int K     = 1,
  parameter int ROUND = 0,
  parameter int SAT   = 0
) (
  input logic              clk,
  input logic              reset,
  fpmult_radix_sat_if.slave io
);
  localparam int W  = 2 * n;
  localparam int NG = n / K;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Half-LSB of the result, applied before the shift when rounding is enabled.
  localparam logic [W:0] RND = (ROUND != 0 && d > 0)
                               ? ((W + 1)'(1) << ((d > 0) ? d - 1 : 0)) : '0;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [W-1:0]  r_a_sh;
  logic [W-1:0]  r_acc;
  logic [n-1:0]  r_b;
  logic [n-1:0]  r_c;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  logic          w_last;
  logic [W-1:0]  w_terms [K];
  logic [W-1:0]  w_pp;
  logic [W-1:0]  w_acc_next;
  logic [W:0]    w_pext;
  logic [W:0]    w_rsum;
  logic signed [W:0] w_r;
  logic          w_ovf;
  logic [n-1:0]  w_c;

  assign w_last = (r_cnt == CW'(NG - 1));

  // One shifted copy of a per digit bit; the operand MSB of a signed multiplier
  // carries negative weight, so its term is negated on the final group only.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_term
      if (sign != 0 && gi == K - 1) begin : g_msb
        assign w_terms[gi] = !r_b[gi] ? '0
                           : (w_last ? -(r_a_sh << gi) : (r_a_sh << gi));
      end else begin : g_plain
        assign w_terms[gi] = r_b[gi] ? (r_a_sh << gi) : '0;
      end
    end
  endgenerate

  always_comb begin
    w_pp = '0;
    for (int j = 0; j < K; j++) begin
      w_pp = w_pp + w_terms[j];
    end
  end

  assign w_acc_next = r_acc + w_pp;

  // One guard bit above the 2n-bit product keeps the rounding add exact.
  assign w_pext = (sign != 0) ? {w_acc_next[W-1], w_acc_next} : {1'b0, w_acc_next};
  assign w_rsum = w_pext + RND;
  assign w_r    = $signed(w_rsum) >>> d;

  always_comb begin
    w_ovf = 1'b0;
    w_c   = w_r[n-1:0];
    if (sign != 0) begin
      w_ovf = (w_r[W:n-1] != '0) && (w_r[W:n-1] != '1);
    end else begin
      w_ovf = (w_r[W:n] != '0);
    end
    if (SAT != 0 && w_ovf) begin
      if (sign != 0) begin
        w_c = w_r[W] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
      end else begin
        w_c = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (io.recv_val) w_state_next = S_CALC;
      S_CALC:  if (w_last)      w_state_next = S_DONE;
      S_DONE:  if (io.send_rdy) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    io.recv_rdy = 1'b0;
    io.send_val = 1'b0;
    case (r_state)
      S_IDLE:  io.recv_rdy = 1'b1;
      S_DONE:  io.send_val = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_sh <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io.recv_val) begin
            r_a_sh <= (sign != 0) ? {{n{io.a[n-1]}}, io.a} : {{n{1'b0}}, io.a};
            r_b    <= io.b;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        S_CALC: begin
          r_acc  <= w_acc_next;
          r_a_sh <= r_a_sh << K;
          r_b    <= r_b >> K;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_c   <= w_c;
            r_ovf <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.c   = r_c;
  assign io.ovf = r_ovf;
endmodule
